// File: rtl/dff_pkg.sv
// Shared constants and width helpers for the register delay line.
// Index and count widths are forced to at least one bit so DEPTH=1 still elaborates.
package dff_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int tap_idx_w(input int depth);
    return clog2_min1(depth);
  endfunction

  function automatic int occ_cnt_w(input int depth);
    return clog2_min1(depth + 1);
  endfunction

endpackage

// File: rtl/dff_stage.sv
// One data + valid register of the delay line.
// Priority on each edge: reset, then clear, then advance.
module dff_stage
  import dff_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_d_valid,
  output logic [WIDTH-1:0] o_q,
  output logic             o_q_valid
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_data  <= RESET_VAL;
      r_valid <= 1'b0;
    end else if (i_en) begin
      r_data  <= i_d;
      r_valid <= i_d_valid;
    end
  end

  assign o_q       = r_data;
  assign o_q_valid = r_valid;

endmodule

// File: rtl/dff_delay_line.sv
// WIDTH-bit, DEPTH-stage retiming delay line with valid tracking, stall, flush,
// a selectable tap and a running count of valid stages.
module dff_delay_line
  import dff_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter int               DEPTH     = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          flush,
  input  logic [WIDTH-1:0]              d,
  input  logic                          d_valid,
  input  logic [tap_idx_w(DEPTH)-1:0]   tap_sel,
  output logic [WIDTH-1:0]              q,
  output logic                          q_valid,
  output logic [WIDTH-1:0]              tap_q,
  output logic                          tap_valid,
  output logic [occ_cnt_w(DEPTH)-1:0]   occupancy,
  output logic                          full
);

  localparam int TAP_W = tap_idx_w(DEPTH);
  localparam int OCC_W = occ_cnt_w(DEPTH);

  logic [WIDTH-1:0] w_chain_d [DEPTH];
  logic             w_chain_v [DEPTH];
  logic [WIDTH-1:0] w_stage_q [DEPTH];
  logic             w_stage_v [DEPTH];
  logic [WIDTH-1:0] w_tap_q;
  logic             w_tap_v;
  logic [OCC_W-1:0] r_occ;

  assign w_chain_d[0] = d;
  assign w_chain_v[0] = d_valid;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    if (gi > 0) begin : g_link
      assign w_chain_d[gi] = w_stage_q[gi-1];
      assign w_chain_v[gi] = w_stage_v[gi-1];
    end

    dff_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (flush),
      .i_en      (en),
      .i_d       (w_chain_d[gi]),
      .i_d_valid (w_chain_v[gi]),
      .o_q       (w_stage_q[gi]),
      .o_q_valid (w_stage_v[gi])
    );
  end

  // Out-of-range selects (non-power-of-2 DEPTH) read as an empty reset stage.
  always_comb begin
    w_tap_q = RESET_VAL;
    w_tap_v = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tap_sel == TAP_W'(i)) begin
        w_tap_q = w_stage_q[i];
        w_tap_v = w_stage_v[i];
      end
    end
  end

  // Entry and exit are tracked together so the count stays within 0..DEPTH.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_occ <= '0;
    end else if (en) begin
      r_occ <= r_occ + OCC_W'(d_valid) - OCC_W'(w_stage_v[DEPTH-1]);
    end
  end

  assign q         = w_stage_q[DEPTH-1];
  assign q_valid   = w_stage_v[DEPTH-1];
  assign tap_q     = w_tap_q;
  assign tap_valid = w_tap_v;
  assign occupancy = r_occ;
  assign full      = (r_occ == OCC_W'(DEPTH));

endmodule

// File: tb/tb_dff_delay_line.sv
// Directed bench for dff_delay_line (WIDTH=8, DEPTH=4, RESET_VAL=0): a vector
// table checked one edge at a time, plus tap sweep and stall-latency sequences.
module tb_dff_delay_line;

  logic       clk;
  logic       rst;
  logic       en;
  logic       flush;
  logic [7:0] d;
  logic       d_valid;
  logic [1:0] tap_sel;
  logic [7:0] q;
  logic       q_valid;
  logic [7:0] tap_q;
  logic       tap_valid;
  logic [2:0] occupancy;
  logic       full;

  int checks;
  int failures;

  dff_delay_line #(
    .WIDTH     (8),
    .DEPTH     (4),
    .RESET_VAL (8'h00)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .flush     (flush),
    .d         (d),
    .d_valid   (d_valid),
    .tap_sel   (tap_sel),
    .q         (q),
    .q_valid   (q_valid),
    .tap_q     (tap_q),
    .tap_valid (tap_valid),
    .occupancy (occupancy),
    .full      (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       flush;
    logic       en;
    logic [7:0] d;
    logic       dv;
    logic [1:0] sel;
    logic [7:0] eq;
    logic       eqv;
    logic [7:0] etq;
    logic       etv;
    logic [2:0] eocc;
    logic       efull;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_tap [4];
  int         edges;
  int         seen;

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b0; en = 1'b0; flush = 1'b0; d = 8'h00; d_valid = 1'b0; tap_sel = 2'd0;

    //                rst  fl   en   d      dv   sel   q      qv   tq     tv   occ   full
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 2'd0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 2'd0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 2'd0, 8'h00, 1'b0, 8'h11, 1'b1, 3'd1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 2'd1, 8'h00, 1'b0, 8'h11, 1'b1, 3'd2, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 2'd2, 8'h00, 1'b0, 8'h11, 1'b1, 3'd3, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h44, 1'b1, 2'd3, 8'h11, 1'b1, 8'h11, 1'b1, 3'd4, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 2'd0, 8'h22, 1'b1, 8'h55, 1'b0, 3'd3, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'h99, 1'b1, 2'd0, 8'h22, 1'b1, 8'h55, 1'b0, 3'd3, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 8'h77, 1'b1, 2'd1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 2'd0, 8'h00, 1'b0, 8'h01, 1'b1, 3'd1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 2'd0, 8'h00, 1'b0, 8'h02, 1'b1, 3'd2, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h03, 1'b1, 2'd0, 8'h00, 1'b0, 8'h03, 1'b1, 3'd3, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 8'h04, 1'b1, 2'd0, 8'h01, 1'b1, 8'h04, 1'b1, 3'd4, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 8'h05, 1'b1, 2'd3, 8'h02, 1'b1, 8'h02, 1'b1, 3'd4, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 8'h06, 1'b1, 2'd2, 8'h03, 1'b1, 8'h04, 1'b1, 3'd4, 1'b1};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 8'h07, 1'b1, 2'd2, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 8'hAA, 1'b1, 2'd0, 8'h00, 1'b0, 8'hAA, 1'b1, 3'd1, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 8'hBB, 1'b1, 2'd1, 8'h00, 1'b0, 8'hAA, 1'b1, 3'd2, 1'b0};
    vecs[18] = '{1'b1, 1'b1, 1'b1, 8'hCC, 1'b1, 2'd1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 1'b1, 8'hDD, 1'b1, 2'd0, 8'h00, 1'b0, 8'hDD, 1'b1, 3'd1, 1'b0};
    vecs[20] = '{1'b1, 1'b0, 1'b0, 8'hEE, 1'b1, 2'd0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};

    step();
    for (int i = 0; i < NVEC; i++) begin
      rst = vecs[i].rst; flush = vecs[i].flush; en = vecs[i].en;
      d = vecs[i].d; d_valid = vecs[i].dv; tap_sel = vecs[i].sel;
      step();
      chk($sformatf("vec%0d {q,qv,tq,tv,occ,full}", i),
          32'({q, q_valid, tap_q, tap_valid, occupancy, full}),
          32'({vecs[i].eq, vecs[i].eqv, vecs[i].etq, vecs[i].etv, vecs[i].eocc, vecs[i].efull}));
    end
    rst = 1'b0;

    // Tap sweep over a stalled line holding 04,03,02,01.
    flush = 1'b1; en = 1'b1; step(); flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = 8'(i + 1); d_valid = 1'b1; step();
    end
    en = 1'b0; d = 8'hEE;
    exp_tap[0] = 8'h04; exp_tap[1] = 8'h03; exp_tap[2] = 8'h02; exp_tap[3] = 8'h01;
    for (int s = 0; s < 4; s++) begin
      tap_sel = 2'(s);
      #1;
      chk($sformatf("tap_sweep sel%0d {tq,tv}", s), 32'({tap_q, tap_valid}), 32'({exp_tap[s], 1'b1}));
    end

    // Stall latency: A1 accepted, three held edges, then advance until q_valid.
    flush = 1'b1; en = 1'b1; step(); flush = 1'b0;
    d = 8'hA1; d_valid = 1'b1; en = 1'b1; step();
    d = 8'h5A; en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("stall%0d {occ,qv}", k), 32'({occupancy, q_valid}), 32'({3'd1, 1'b0}));
    end
    edges = 3;
    seen = 0;
    en = 1'b1; d_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (seen == 0) begin
        step();
        edges++;
        if (q_valid) seen = 1;
      end
    end
    if (seen == 0) edges = -1;
    chk("stall_latency_edges", 32'(edges), 32'd6);
    chk("stall_latency_q", 32'(q), 32'h0000_00A1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
